sfp_feeder: RTL and testbench
=============================

Name: sfp_feeder

Overview:
- Upstream neighbour of the SFP row. Accumulates column partial-sum vectors from the MAC-array output stream over several passes into an internal row buffer.
- Replays the buffered rows twice: once with `acc` asserted, so the SFP builds per-row abs-sums, then once with `div` asserted, so the SFP normalises each row.
- Also drives the external-sum FIFO read strobe and a `sfp_out` valid qualifier for the downstream writer.

Parameters:
- col, 8, lanes per row vector
- bw, 8, activation/weight width (informational)
- bw_psum, 2*bw+4, signed partial-sum width per lane
- rows, 16, row-buffer depth (matches SFP FIFO depth)
- addr_w, 4, log2(rows)
- gap_cyc, 2, idle cycles between last `acc` beat and first `div` beat

Ports:
- clk  input  1  clock
- reset  input  1  reset
- start  input  1  one-cycle pulse; begins a job (sampled only in IDLE)
- num_rows  input  addr_w+1  rows per job, 1..rows, sampled at start
- num_pass  input  4  accumulation passes, 1..15, sampled at start
- in_valid  input  1  psum beat valid
- in_ready  output  1  block accepts beat
- in_data  input  col*bw_psum  signed psum vector, lane0 in LSBs
- sfp_data  output  col*bw_psum  row vector to SFP `sfp_in`
- acc  output  1  SFP accumulate strobe
- div  output  1  SFP divide strobe
- fifo_ext_rd  output  1  external-sum FIFO read, equal to `div`
- sfp_out_valid  output  1  `div` delayed one cycle; qualifies SFP `sfp_out`
- busy  output  1  high in any state except IDLE
- done  output  1  one-cycle pulse at end of job

Behaviour:
- Reset is asynchronous and active-high. Reset clears the FSM to IDLE and sets every output to 0 (`sfp_data` = 0). Row-buffer contents are don't-care after reset.
- Reset mid-job abandons the job. No `acc`/`div`/`done` is produced after reset deasserts until a new start.
- Five states: IDLE, ACCUM, EMIT_ACC, GAP, EMIT_DIV.
- IDLE:
  - `in_ready`=0.
  - On `start`: if `num_rows`==0, `num_rows`>rows, or `num_pass`==0, stay in IDLE (ignored, no `done`).
  - Otherwise latch both values, clear `row_cnt`/`pass_cnt`, and go to ACCUM.
- ACCUM:
  - `in_ready`=1. Each handshake (`in_valid` & `in_ready`) processes `buf[row_cnt]`.
  - Pass 0: `buf[row_cnt]` = `in_data` (overwrite).
  - Later passes: lane-wise signed add, wrapping modulo 2^bw_psum.
  - `row_cnt` wraps at `num_rows`-1 and then increments `pass_cnt`.
  - After beat `num_rows*num_pass` is accepted, next state is EMIT_ACC.
  - Cycles without a handshake hold all state.
- EMIT_ACC:
  - One row per cycle, i = 0..`num_rows`-1. `sfp_data`=`buf[i]` and `acc`=1 are registered and aligned in the same cycle.
  - Then GAP.
- GAP: `gap_cyc` cycles with `acc`=`div`=0 and `sfp_data` held. Then EMIT_DIV.
- EMIT_DIV:
  - One row per cycle, same order. `sfp_data`=`buf[i]`, with `div`=`fifo_ext_rd`=1.
  - `sfp_out_valid` follows one cycle later.
  - After the last row: `done`=1 for one cycle, then IDLE.
- Throughput: total cycles from the last accepted beat to `done` = 2*`num_rows` + `gap_cyc` + 1.
- `start` while `busy` is ignored. `in_valid` outside ACCUM is ignored and never consumed.
- `acc` and `div` are never high in the same cycle.

Optional Feature:
- Macro: PSUM_SAT_EN.
- Defined: pass≥1 accumulation saturates each lane to [-2^(bw_psum-1), 2^(bw_psum-1)-1]. A sticky output `sat_flag` (1 bit) is set on any clamp and cleared on `start` or reset.
- Undefined: lanes wrap modulo 2^bw_psum, and the `sat_flag` port does not exist.

Test Plan:
- Basic job:
  - Stimulus: `start` with `num_rows`=2, `num_pass`=1; beats row0 = all lanes 5, row1 = all lanes -3.
  - Required: `acc` high two consecutive cycles carrying 5s then -3s; two gap cycles; `div` high two cycles with the same data; `sfp_out_valid` lags `div` by 1; `done` one cycle after the last `div`.
- Multi-pass:
  - Stimulus: `num_rows`=3, `num_pass`=3; beat value = 10*pass+row in lane0.
  - Required: emitted lane0 rows = 30, 33, 36.
- Backpressure gaps:
  - Stimulus: `in_valid` toggled randomly in ACCUM.
  - Required: the same result as the gapless case; no beat dropped or duplicated.
- Illegal/ignored inputs:
  - Stimulus: `start` with `num_rows`=0, then with `num_pass`=0.
  - Required: `busy` stays 0 and no `done`.
  - Stimulus: `start` pulsed during EMIT_ACC.
  - Required: job unaffected.
- Reset mid-op:
  - Stimulus: assert `reset` asynchronously mid-EMIT_DIV.
  - Required: all outputs 0 immediately and the FSM in IDLE; after release, a fresh `num_rows`=1 job completes correctly.
- Overflow:
  - Stimulus: two passes of lane value 2^(bw_psum-1)-1.
  - Required without PSUM_SAT_EN: result -2.
  - Required with PSUM_SAT_EN: result 2^(bw_psum-1)-1 and `sat_flag`=1.

Source files
------------

// File: rtl/sfp_feeder_if.sv
// sfp_feeder_if: job control, psum input stream and SFP-facing row stream.
// With PSUM_SAT_EN defined the interface also carries the sticky sat_flag.
interface sfp_feeder_if #(
  parameter int COL     = 8,
  parameter int BW_PSUM = 20,
  parameter int ADDR_W  = 4
);
  logic                     start;
  logic [ADDR_W:0]          num_rows;
  logic [3:0]               num_pass;
  logic                     in_valid;
  logic                     in_ready;
  logic [COL*BW_PSUM-1:0]   in_data;
  logic [COL*BW_PSUM-1:0]   sfp_data;
  logic                     acc;
  logic                     div;
  logic                     fifo_ext_rd;
  logic                     sfp_out_valid;
  logic                     busy;
  logic                     done;
`ifdef PSUM_SAT_EN
  logic                     sat_flag;
`endif

  modport master (
    output start, num_rows, num_pass, in_valid, in_data,
    input  in_ready, sfp_data, acc, div, fifo_ext_rd, sfp_out_valid, busy, done
`ifdef PSUM_SAT_EN
    , input sat_flag
`endif
  );

  modport slave (
    input  start, num_rows, num_pass, in_valid, in_data,
    output in_ready, sfp_data, acc, div, fifo_ext_rd, sfp_out_valid, busy, done
`ifdef PSUM_SAT_EN
    , output sat_flag
`endif
  );
endinterface

// File: rtl/sfp_feeder.sv
// sfp_feeder: accumulates psum row vectors over several passes into a row
// buffer, then replays the rows to the SFP twice (acc sweep, gap, div sweep).
// Optional macro PSUM_SAT_EN: saturating accumulation plus sticky sat_flag;
// when undefined, lanes wrap modulo 2^BW_PSUM.
module sfp_feeder #(
  parameter int COL     = 8,
  parameter int BW      = 8,
  parameter int BW_PSUM = 2*BW+4,
  parameter int ROWS    = 16,
  parameter int ADDR_W  = 4,
  parameter int GAP_CYC = 2
) (
  input  logic          clk,
  input  logic          reset,
  sfp_feeder_if.slave   bus
);
  localparam int VW = COL*BW_PSUM;
  localparam int RW = ADDR_W+1;

  typedef enum logic [2:0] {IDLE, ACCUM, EMIT_ACC, GAP, EMIT_DIV} state_t;

  state_t         state_q, state_d;
  logic [RW-1:0]  row_q, row_d, nrows_q, nrows_d;
  logic [3:0]     pass_q, pass_d, npass_q, npass_d;
  logic [VW-1:0]  rbuf_q [ROWS];
  logic [VW-1:0]  sfp_data_q, sfp_data_d;
  logic [VW-1:0]  cur_row, wr_val, rd_val;
  logic           acc_q, acc_d, div_q, div_d, ovld_q, done_q, done_d;
  logic           wr_en, last_row, start_ok;

  assign start_ok = bus.start && (bus.num_rows != '0) &&
                    (bus.num_rows <= RW'(ROWS)) && (bus.num_pass != '0);
  assign wr_en    = (state_q == ACCUM) && bus.in_valid;
  assign last_row = (row_q == nrows_q - RW'(1));
  assign cur_row  = rbuf_q[row_q[ADDR_W-1:0]];

`ifdef PSUM_SAT_EN
  logic [COL-1:0] clamp;
  logic           sat_q, sat_d;
`endif

  // Per-lane pass-0 overwrite or signed accumulate of the addressed row
  for (genvar l = 0; l < COL; l++) begin : g_lane
    logic signed [BW_PSUM-1:0] a, b;
    assign a = cur_row[l*BW_PSUM +: BW_PSUM];
    assign b = bus.in_data[l*BW_PSUM +: BW_PSUM];
`ifdef PSUM_SAT_EN
    logic signed [BW_PSUM:0] s;
    assign s        = {a[BW_PSUM-1], a} + {b[BW_PSUM-1], b};
    // sign bits disagree -> result left the representable range
    assign clamp[l] = s[BW_PSUM] != s[BW_PSUM-1];
    assign wr_val[l*BW_PSUM +: BW_PSUM] =
      (pass_q == '0) ? b :
      clamp[l]       ? {s[BW_PSUM], {(BW_PSUM-1){~s[BW_PSUM]}}} :
                       s[BW_PSUM-1:0];
`else
    logic signed [BW_PSUM-1:0] s;
    assign s = a + b;
    assign wr_val[l*BW_PSUM +: BW_PSUM] = (pass_q == '0) ? b : s;
`endif
  end

  // Output rows are loaded on entry to an emit state, so the row being read
  // may be the one written on that same edge (single-row jobs): bypass it.
  assign rd_val = (wr_en && (row_d == row_q)) ? wr_val : rbuf_q[row_d[ADDR_W-1:0]];

  // Row buffer write; contents need no reset
  always_ff @(posedge clk)
    if (wr_en) rbuf_q[row_q[ADDR_W-1:0]] <= wr_val;

  // State, counters and registered outputs
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q    <= IDLE;
      row_q      <= '0;
      pass_q     <= '0;
      nrows_q    <= '0;
      npass_q    <= '0;
      sfp_data_q <= '0;
      acc_q      <= 1'b0;
      div_q      <= 1'b0;
      ovld_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef PSUM_SAT_EN
      sat_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      pass_q     <= pass_d;
      nrows_q    <= nrows_d;
      npass_q    <= npass_d;
      sfp_data_q <= sfp_data_d;
      acc_q      <= acc_d;
      div_q      <= div_d;
      ovld_q     <= div_q;
      done_q     <= done_d;
`ifdef PSUM_SAT_EN
      sat_q      <= sat_d;
`endif
    end

  // Next state; row_q doubles as beat row, emit index and gap counter
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    pass_d  = pass_q;
    nrows_d = nrows_q;
    npass_d = npass_q;
    unique case (state_q)
      IDLE:
        if (start_ok) begin
          state_d = ACCUM;
          row_d   = '0;
          pass_d  = '0;
          nrows_d = bus.num_rows;
          npass_d = bus.num_pass;
        end
      ACCUM:
        if (wr_en) begin
          if (last_row) begin
            row_d = '0;
            if (pass_q == npass_q - 4'd1) state_d = EMIT_ACC;
            else                          pass_d  = pass_q + 4'd1;
          end else row_d = row_q + RW'(1);
        end
      EMIT_ACC:
        if (last_row) begin state_d = GAP; row_d = '0; end
        else row_d = row_q + RW'(1);
      GAP:
        if (row_q == RW'(GAP_CYC-1)) begin state_d = EMIT_DIV; row_d = '0; end
        else row_d = row_q + RW'(1);
      EMIT_DIV:
        if (last_row) begin state_d = IDLE; row_d = '0; end
        else row_d = row_q + RW'(1);
      default: state_d = IDLE;
    endcase
  end

  // Output next-values, aligned with the state being entered
  always_comb begin
    acc_d      = (state_d == EMIT_ACC);
    div_d      = (state_d == EMIT_DIV);
    done_d     = (state_q == EMIT_DIV) && last_row;
    sfp_data_d = (acc_d || div_d) ? rd_val : sfp_data_q;
`ifdef PSUM_SAT_EN
    sat_d = sat_q;
    if ((state_q == IDLE) && bus.start)               sat_d = 1'b0;
    else if (wr_en && (pass_q != '0) && (|clamp))     sat_d = 1'b1;
`endif
  end

  assign bus.in_ready      = (state_q == ACCUM);
  assign bus.busy          = (state_q != IDLE);
  assign bus.sfp_data      = sfp_data_q;
  assign bus.acc           = acc_q;
  assign bus.div           = div_q;
  assign bus.fifo_ext_rd   = div_q;
  assign bus.sfp_out_valid = ovld_q;
  assign bus.done          = done_q;
`ifdef PSUM_SAT_EN
  assign bus.sat_flag      = sat_q;
`endif
endmodule

// File: tb/tb_sfp_feeder.sv
// tb_sfp_feeder: randomized job stimulus checked against a per-row
// arithmetic model and the expected emit schedule.
module tb_sfp_feeder;
  localparam int COL = 8, BW = 8, BW_PSUM = 20, ROWS = 16, ADDR_W = 4, GAP = 2;
  localparam int VW = COL*BW_PSUM;
  localparam int MAXV = (1 << (BW_PSUM-1)) - 1;
  localparam int MINV = -(1 << (BW_PSUM-1));

  logic clk = 1'b0, reset = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0, n_bad = 0;

  logic [VW-1:0] beats [16][16];   // [pass][row]
  logic [VW-1:0] expv  [16];

  sfp_feeder_if #(.COL(COL), .BW_PSUM(BW_PSUM), .ADDR_W(ADDR_W)) bus();

  sfp_feeder #(.COL(COL), .BW(BW), .BW_PSUM(BW_PSUM), .ROWS(ROWS),
               .ADDR_W(ADDR_W), .GAP_CYC(GAP))
    dut (.clk(clk), .reset(reset), .bus(bus.slave));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int sx(input logic [BW_PSUM-1:0] x);
    int t;
    t = {{(32-BW_PSUM){x[BW_PSUM-1]}}, x};
    return t;
  endfunction

  function automatic logic [VW-1:0] rnd_vec();
    logic [VW-1:0] v;
    for (int l = 0; l < COL; l++) v[l*BW_PSUM +: BW_PSUM] = BW_PSUM'($urandom);
    return v;
  endfunction

  // Reference: per lane, first pass overwrites, later passes add (wrap/clamp)
  task automatic compute_exp(input int n, input int p);
    for (int r = 0; r < n; r++)
      for (int l = 0; l < COL; l++) begin
        int s;
        s = 0;
        for (int q = 0; q < p; q++) begin
          int v;
          v = sx(beats[q][r][l*BW_PSUM +: BW_PSUM]);
          if (q == 0) s = v;
          else begin
            s = s + v;
`ifdef PSUM_SAT_EN
            if (s > MAXV) s = MAXV;
            if (s < MINV) s = MINV;
`else
            s = sx(s[BW_PSUM-1:0]);
`endif
          end
        end
        expv[r][l*BW_PSUM +: BW_PSUM] = s[BW_PSUM-1:0];
      end
  endtask

  task automatic fill_rand(input int n, input int p);
    for (int q = 0; q < p; q++)
      for (int r = 0; r < n; r++) beats[q][r] = rnd_vec();
  endtask

  task automatic start_job(input int n, input int p);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.num_rows = (ADDR_W+1)'(n);
    bus.num_pass = 4'(p);
  endtask

  // Feeds n*p beats; c0 = cycle in which the last beat handshakes
  task automatic feed(input int n, input int p, input bit gaps, output int c0);
    int k, guard;
    k = 0; guard = 0; c0 = 0;
    while (k < n*p && guard < 4000) begin
      @(negedge clk);
      guard++;
      bus.start = 1'b0;
      if (gaps && $urandom_range(0, 2) == 0) begin
        bus.in_valid = 1'b0;
        bus.in_data  = rnd_vec();
      end else begin
        bus.in_valid = 1'b1;
        bus.in_data  = beats[k/n][k%n];
        if (bus.in_ready) begin k++; c0 = cyc; end
      end
    end
    n_cmp++;
    if (k != n*p) begin
      n_bad++;
      $display("FAIL feed_timeout: accepted %0d beats, need %0d", k, n*p);
    end
  endtask

  // Watches one job's replay and checks schedule, data and strobes
  task automatic monitor(input int n, input int c0, input bit poke);
    int ai, di, guard;
    bit got_done;
    logic prev_div;
    ai = 0; di = 0; guard = 0; got_done = 0; prev_div = 1'b0;
    while (!got_done && guard < 200) begin
      @(negedge clk);
      guard++;
      bus.start    = 1'b0;
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.in_data  = rnd_vec();
      if (poke && bus.acc && ai == 0) begin
        bus.start = 1'b1; bus.num_rows = 5'd1; bus.num_pass = 4'd1;
      end
      n_cmp++;
      if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL in_ready_emit: got %b want 0 at cyc %0d", bus.in_ready, cyc); end
      n_cmp++;
      if (bus.acc && bus.div) begin n_bad++; $display("FAIL acc_div_overlap: both high at cyc %0d", cyc); end
      n_cmp++;
      if (bus.fifo_ext_rd !== bus.div) begin n_bad++; $display("FAIL fifo_ext_rd: got %b want %b", bus.fifo_ext_rd, bus.div); end
      n_cmp++;
      if (bus.sfp_out_valid !== prev_div) begin n_bad++; $display("FAIL sfp_out_valid: got %b want %b at cyc %0d", bus.sfp_out_valid, prev_div, cyc); end
      prev_div = bus.div;
      if (bus.acc) begin
        n_cmp++;
        if (cyc != c0 + 1 + ai) begin n_bad++; $display("FAIL acc_cycle: row %0d at cyc %0d want %0d", ai, cyc, c0+1+ai); end
        n_cmp++;
        if (ai >= n || bus.sfp_data !== expv[ai]) begin n_bad++; $display("FAIL acc_data row %0d: got %h want %h", ai, bus.sfp_data, expv[ai % 16]); end
        ai++;
      end
      if (bus.div) begin
        n_cmp++;
        if (cyc != c0 + 1 + n + GAP + di) begin n_bad++; $display("FAIL div_cycle: row %0d at cyc %0d want %0d", di, cyc, c0+1+n+GAP+di); end
        n_cmp++;
        if (di >= n || bus.sfp_data !== expv[di]) begin n_bad++; $display("FAIL div_data row %0d: got %h want %h", di, bus.sfp_data, expv[di % 16]); end
        di++;
      end
      if (!bus.acc && !bus.div && ai == n && di == 0) begin
        n_cmp++;
        if (bus.sfp_data !== expv[n-1]) begin n_bad++; $display("FAIL gap_hold: got %h want %h", bus.sfp_data, expv[n-1]); end
      end
      if (bus.done) begin
        got_done = 1;
        n_cmp++;
        if (cyc != c0 + 2*n + GAP + 1) begin n_bad++; $display("FAIL done_cycle: got %0d want %0d", cyc, c0+2*n+GAP+1); end
        n_cmp++;
        if (ai != n || di != n) begin n_bad++; $display("FAIL row_count: acc %0d div %0d want %0d", ai, di, n); end
        n_cmp++;
        if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL busy_at_done: got %b want 0", bus.busy); end
      end else begin
        n_cmp++;
        if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL busy_job: got %b want 1 at cyc %0d", bus.busy, cyc); end
      end
    end
    if (!got_done) begin n_cmp++; n_bad++; $display("FAIL done_timeout: no done within 200 cycles"); end
    @(negedge clk);
    bus.start = 1'b0;
    n_cmp++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      n_bad++; $display("FAIL post_done: done %b busy %b want 0 0", bus.done, bus.busy);
    end
  endtask

  task automatic run_job(input int n, input int p, input bit gaps, input bit poke);
    int c0;
    compute_exp(n, p);
    start_job(n, p);
    feed(n, p, gaps, c0);
    monitor(n, c0, poke);
  endtask

  task automatic check_idle_outputs(input string tag);
    n_cmp++;
    if (bus.acc !== 0 || bus.div !== 0 || bus.fifo_ext_rd !== 0 || bus.sfp_out_valid !== 0 ||
        bus.done !== 0 || bus.busy !== 0 || bus.in_ready !== 0 || bus.sfp_data !== '0) begin
      n_bad++;
      $display("FAIL %s: acc %b div %b rd %b ov %b done %b busy %b rdy %b data %h want all 0",
               tag, bus.acc, bus.div, bus.fifo_ext_rd, bus.sfp_out_valid, bus.done,
               bus.busy, bus.in_ready, bus.sfp_data);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    check_idle_outputs("reset_state");
`ifdef PSUM_SAT_EN
    n_cmp++;
    if (bus.sat_flag !== 1'b0) begin n_bad++; $display("FAIL reset_sat_flag: got %b want 0", bus.sat_flag); end
`endif
    reset = 1'b0;
  endtask

  task automatic test_basic();
    for (int l = 0; l < COL; l++) begin
      beats[0][0][l*BW_PSUM +: BW_PSUM] = 20'd5;
      beats[0][1][l*BW_PSUM +: BW_PSUM] = -20'sd3;
    end
    run_job(2, 1, 0, 0);
  endtask

  task automatic test_multipass();
    for (int q = 0; q < 3; q++)
      for (int r = 0; r < 3; r++) begin
        beats[q][r] = '0;
        beats[q][r][BW_PSUM-1:0] = BW_PSUM'(10*q + r);
      end
    run_job(3, 3, 0, 0);
  endtask

  task automatic test_backpressure();
    int n, p;
    n = $urandom_range(2, 16);
    p = $urandom_range(1, 4);
    fill_rand(n, p);
    run_job(n, p, 0, 0);
    run_job(n, p, 1, 0);
  endtask

  task automatic test_illegal();
    int nr [3] = '{0, 5, 17};
    int np [3] = '{1, 0, 1};
    for (int t = 0; t < 3; t++) begin
      start_job(nr[t], np[t]);
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        bus.start = 1'b0;
        n_cmp++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
          n_bad++; $display("FAIL illegal_start rows %0d pass %0d: busy %b done %b want 0 0", nr[t], np[t], bus.busy, bus.done);
        end
      end
    end
  endtask

  task automatic test_start_during_emit();
    fill_rand(4, 2);
    run_job(4, 2, 0, 1);
  endtask

  task automatic test_reset_mid();
    int c0, guard;
    fill_rand(4, 1);
    compute_exp(4, 1);
    start_job(4, 1);
    feed(4, 1, 0, c0);
    guard = 0;
    do begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      guard++;
    end while (!bus.div && guard < 50);
    n_cmp++;
    if (!bus.div) begin n_bad++; $display("FAIL reset_mid_no_div: div never rose"); end
    #3 reset = 1'b1;
    #1 check_idle_outputs("reset_async");
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.acc !== 0 || bus.div !== 0 || bus.done !== 0 || bus.busy !== 0) begin
        n_bad++; $display("FAIL post_reset_quiet: acc %b div %b done %b busy %b want 0", bus.acc, bus.div, bus.done, bus.busy);
      end
    end
    fill_rand(1, 2);
    run_job(1, 2, 1, 0);
  endtask

  task automatic test_overflow();
    for (int q = 0; q < 2; q++)
      for (int l = 0; l < COL; l++) beats[q][0][l*BW_PSUM +: BW_PSUM] = BW_PSUM'(MAXV);
    run_job(1, 2, 0, 0);
`ifdef PSUM_SAT_EN
    n_cmp++;
    if (bus.sat_flag !== 1'b1) begin n_bad++; $display("FAIL sat_flag_set: got %b want 1", bus.sat_flag); end
    test_basic();
    n_cmp++;
    if (bus.sat_flag !== 1'b0) begin n_bad++; $display("FAIL sat_flag_clear: got %b want 0", bus.sat_flag); end
`endif
  endtask

  task automatic test_random_jobs();
    for (int j = 0; j < 4; j++) begin
      int n, p;
      n = $urandom_range(1, 16);
      p = $urandom_range(1, 5);
      fill_rand(n, p);
      run_job(n, p, 1'($urandom_range(0, 1)), 0);
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.num_rows = '0; bus.num_pass = '0;
    bus.in_valid = 1'b0; bus.in_data = '0;
    test_reset();
    test_basic();
    test_multipass();
    test_backpressure();
    test_illegal();
    test_start_during_emit();
    test_reset_mid();
    test_overflow();
    test_random_jobs();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
